// File: rtl/alu_result_bcd.sv
// alu_result_bcd: converts the ALU result magnitude to packed BCD.
// A sequential shift-add-3 (double-dabble) engine processes one bit per clock.
// Valid/ready handshakes on both sides let the display driver apply backpressure.
module alu_result_bcd #(
  parameter int VAL_W  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  output logic                  ready_in,
  input  logic [1:0]            opcode,
  input  logic [7:0]            out,
  input  logic [7:0]            extended_out,
  input  logic                  carry,
  input  logic                  overflow,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [2:0]            num_digits,
  output logic                  ovf_out,
  output logic                  bcd_valid,
  input  logic                  bcd_ready
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int TOT_W = BCD_W + VAL_W;
  localparam int CNT_W = $clog2(VAL_W);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // The BCD accumulator (upper BCD_W bits) and the binary shift register
  // (lower VAL_W bits) are one vector, so each step is a single left shift.
  logic [TOT_W-1:0] shift_q;
  logic [TOT_W-1:0] shift_next;
  logic [BCD_W-1:0] bcd_adj;
  logic [CNT_W-1:0] cnt;
  logic             last_shift;
  logic [VAL_W-1:0] magnitude;
  logic [2:0]       sig_digits;

  // Select the true unsigned magnitude of the issued operation.
  always_comb begin
    // NOTE: every combinational output gets a default first; a path that
    // leaves it unassigned would otherwise infer a latch.
    magnitude = '0;
    case (opcode)
      OP_ADD:  magnitude = VAL_W'({carry, out});
      OP_AND,
      OP_XOR:  magnitude = VAL_W'(out);
      OP_MUL:  magnitude = VAL_W'({extended_out, out});
      default: magnitude = '0;
    endcase
  end

  // Add 3 to every accumulator nibble >= 5, then shift the combined vector.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (shift_q[VAL_W + 4*i +: 4] >= 4'd5)
        bcd_adj[4*i +: 4] = shift_q[VAL_W + 4*i +: 4] + 4'd3;
      else
        bcd_adj[4*i +: 4] = shift_q[VAL_W + 4*i +: 4];
    end
    shift_next = {bcd_adj, shift_q[VAL_W-1:0]} << 1;
  end

  assign last_shift = (cnt == CNT_W'(VAL_W - 1));

  // Significant digit count of the final BCD value; zero still shows one digit.
  always_comb begin
    sig_digits = 3'd1;
    for (int i = 0; i < DIGITS; i++) begin
      if (shift_next[VAL_W + 4*i +: 4] != 4'd0)
        sig_digits = 3'(i + 1);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_in) state_next = CONV;
      CONV:    if (last_shift) state_next = DONE;
      DONE:    if (bcd_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ready_in = (state == IDLE);

  // Conversion datapath and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state here is a few flops, not a memory array, so every
    // register is reset; a reset mid-conversion discards the in-flight result.
    if (!rst_n) begin
      shift_q    <= '0;
      cnt        <= '0;
      bcd        <= '0;
      num_digits <= 3'd1;
      ovf_out    <= 1'b0;
      bcd_valid  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid_in) begin
            shift_q <= {{BCD_W{1'b0}}, magnitude};
            cnt     <= '0;
            ovf_out <= overflow;
          end
        end
        CONV: begin
          shift_q <= shift_next;
          cnt     <= cnt + 1'b1;
          if (last_shift) begin
            bcd        <= shift_next[TOT_W-1 -: BCD_W];
            num_digits <= sig_digits;
            bcd_valid  <= 1'b1;
          end
        end
        DONE: begin
          if (bcd_ready) bcd_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_bcd.sv
// tb_alu_result_bcd: scoreboard bench for alu_result_bcd.
// The driver pushes expected results from a decimal reference model; a
// separate monitor pops and compares on every output handshake.
module tb_alu_result_bcd;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic        ready_in;
  logic [1:0]  opcode = '0;
  logic [7:0]  out = '0;
  logic [7:0]  extended_out = '0;
  logic        carry = 1'b0;
  logic        overflow = 1'b0;
  logic [19:0] bcd;
  logic [2:0]  num_digits;
  logic        ovf_out;
  logic        bcd_valid;
  logic        bcd_ready = 1'b0;

  typedef struct {
    logic [19:0] bcd;
    logic [2:0]  nd;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_result_bcd dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .opcode       (opcode),
    .out          (out),
    .extended_out (extended_out),
    .carry        (carry),
    .overflow     (overflow),
    .bcd          (bcd),
    .num_digits   (num_digits),
    .ovf_out      (ovf_out),
    .bcd_valid    (bcd_valid),
    .bcd_ready    (bcd_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal reference: magnitude from the opcode rules, digits by division.
  function automatic exp_t model(input logic [1:0] op, input logic [7:0] o,
                                 input logic [7:0] e, input logic c, input logic ov);
    exp_t r;
    int unsigned m;
    int unsigned p;
    case (op)
      2'b00:   m = o + (c ? 256 : 0);
      2'b11:   m = e * 256 + o;
      default: m = o;
    endcase
    r.bcd = '0;
    r.nd  = 3'd1;
    p = 1;
    for (int i = 0; i < 5; i++) begin
      r.bcd = r.bcd | (20'((m / p) % 10) << (4 * i));
      if (i > 0 && m >= p) r.nd = 3'(i + 1);
      p = p * 10;
    end
    r.ovf = ov;
    return r;
  endfunction

  // Monitor: compare each result that the consumer accepts.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bcd_valid && bcd_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(bcd), 32'hFFFFFFFF);
        end else begin
          e = sb.pop_front();
          check("bcd", 32'(bcd), 32'(e.bcd));
          check("num_digits", 32'(num_digits), 32'(e.nd));
          check("ovf_out", 32'(ovf_out), 32'(e.ovf));
        end
      end
    end
  end

  // Present one result; called and returns at 1 time unit after a rising edge.
  task automatic accept(input logic [1:0] op, input logic [7:0] o, input logic [7:0] e,
                        input logic c, input logic ov);
    int waitc = 0;
    while (!ready_in && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!ready_in) check("ready_timeout", 32'(ready_in), 32'd1);
    valid_in = 1'b1; opcode = op; out = o; extended_out = e; carry = c; overflow = ov;
    sb.push_back(model(op, o, e, c, ov));
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic wait_latency();
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (i == 15) check("early_valid", 32'(bcd_valid), 32'd0);
    end
    check("latency", 32'(bcd_valid), 32'd1);
  endtask

  task automatic release_result(input int hold);
    bcd_ready = 1'b0;
    repeat (hold) begin @(posedge clk); #1; end
    bcd_ready = 1'b1;
    @(posedge clk); #1;
    bcd_ready = 1'b0;
    check("idle_after_hs", 32'(ready_in), 32'd1);
  endtask

  task automatic run(input logic [1:0] op, input logic [7:0] o, input logic [7:0] e,
                     input logic c, input logic ov, input int hold);
    accept(op, o, e, c, ov);
    wait_latency();
    release_result(hold);
  endtask

  initial begin
    exp_t ex;
    #12;
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_nd", 32'(num_digits), 32'd1);
    check("rst_valid", 32'(bcd_valid), 32'd0);
    check("rst_ready", 32'(ready_in), 32'd1);
    check("rst_ovf", 32'(ovf_out), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases.
    run(2'b00, 8'h08, 8'h00, 1'b0, 1'b0, 0);
    run(2'b00, 8'h2C, 8'h00, 1'b1, 1'b0, 1);
    run(2'b10, 8'hFF, 8'h00, 1'b1, 1'b0, 0);
    run(2'b11, 8'h01, 8'hFE, 1'b0, 1'b0, 2);
    run(2'b11, 8'hFF, 8'hFF, 1'b0, 1'b0, 0);
    run(2'b01, 8'h00, 8'h00, 1'b1, 1'b1, 0);

    // Backpressure: result held while new data is offered.
    accept(2'b11, 8'h15, 8'h00, 1'b0, 1'b0);
    ex = model(2'b11, 8'h15, 8'h00, 1'b0, 1'b0);
    wait_latency();
    bcd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        valid_in = 1'b1; opcode = 2'b11; out = 8'h99; extended_out = 8'h99;
      end
      if (i == 2) valid_in = 1'b0;
      check("bp_ready_low", 32'(ready_in), 32'd0);
      check("bp_bcd_stable", 32'(bcd), 32'(ex.bcd));
    end
    check("bp_valid_held", 32'(bcd_valid), 32'd1);
    release_result(0);
    check("bp_valid_drop", 32'(bcd_valid), 32'd0);

    // Reset in the middle of a conversion.
    accept(2'b11, 8'h34, 8'h12, 1'b0, 1'b1);
    repeat (8) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    void'(sb.pop_back());
    #1;
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    check("mid_rst_valid", 32'(bcd_valid), 32'd0);
    check("mid_rst_ready", 32'(ready_in), 32'd1);
    check("mid_rst_ovf", 32'(ovf_out), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    run(2'b00, 8'h0C, 8'h00, 1'b0, 1'b0, 0);

    // Randomized traffic.
    for (int n = 0; n < 40; n++) begin
      run(2'($urandom_range(3)), 8'($urandom), 8'($urandom), 1'($urandom),
          1'($urandom), int'($urandom_range(3)));
    end

    repeat (3) @(posedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
